// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
//   Owns the architectural fetch PC and the instruction fetch path. Word fetches
//   are issued in order to instruction memory, and the returned words are kept in
//   a small FIFO for decode. CurrentPC (the PC of the head instruction) feeds back
//   to the next-PC logic. A Redirect flushes the queue and marks every in-flight
//   fetch as wrong-path. The unit then stays in DRAIN until those responses have
//   come back, and fetch resumes at NextPC after that.
//
// Ports
//   CLK           in   clock, rising edge
//   Reset         in   synchronous, active-high
//   NextPC        in   redirect target, low two bits ignored
//   Redirect      in   flush and resume at NextPC
//   IMemReqValid  out  fetch request valid (credit-limited)
//   IMemReqAddr   out  word-aligned fetch address
//   IMemReqReady  in   memory accepts the request
//   IMemRspValid  in   in-order response valid, never back-pressured
//   IMemRspData   in   instruction word
//   InstValid     out  head of queue valid
//   Instruction   out  head instruction word
//   CurrentPC     out  PC of the head instruction
//   InstReady     in   decode consumes the head
module pc_fetch_unit #(
  parameter logic [63:0] RESET_PC    = 64'h0,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [63:0] NextPC,
  input  logic        Redirect,
  output logic        IMemReqValid,
  output logic [63:0] IMemReqAddr,
  input  logic        IMemReqReady,
  input  logic        IMemRspValid,
  input  logic [31:0] IMemRspData,
  output logic        InstValid,
  output logic [31:0] Instruction,
  output logic [63:0] CurrentPC,
  input  logic        InstReady
);

  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);
  localparam logic [CNT_W:0]   DEPTH_EXT = (CNT_W + 1)'(QUEUE_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ZERO  = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1'b1);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(QUEUE_DEPTH - 1);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [63:0]      fetch_pc_r, fetch_pc_nxt_s;
  logic [63:0]      rsp_pc_r, rsp_pc_nxt_s;     // PC owed to the next kept response
  logic [CNT_W-1:0] outstanding_r, out_nxt_s;
  logic [CNT_W-1:0] drop_cnt_r, drop_nxt_s;
  logic [CNT_W-1:0] count_r, count_nxt_s, remain_s;
  logic [PTR_W-1:0] rd_ptr_r, rd_ptr_nxt_s;
  logic [PTR_W-1:0] wr_ptr_r, wr_ptr_nxt_s;
  logic [31:0]      q_inst_r [QUEUE_DEPTH];
  logic [63:0]      q_pc_r   [QUEUE_DEPTH];
  logic             inst_valid_r, head_valid_nxt_s;
  logic [31:0]      instruction_r, head_inst_nxt_s;
  logic [63:0]      current_pc_r, head_pc_nxt_s;
  logic [63:0]      redirect_pc_s;
  logic             credit_ok_s, req_fire_s, rsp_take_s, push_s, pop_s;

  // Advance a queue pointer with wrap at the queue depth.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_LAST) begin
      return PTR_ZERO;
    end else begin
      return p + PTR_ONE;
    end
  endfunction

  // The credit check counts in-flight fetches as occupied slots, so a response always finds room.
  assign credit_ok_s   = ({1'b0, outstanding_r} + {1'b0, count_r}) < DEPTH_EXT;
  assign req_fire_s    = IMemReqValid & IMemReqReady;
  assign rsp_take_s    = IMemRspValid & (outstanding_r != CNT_ZERO);
  assign push_s        = rsp_take_s & (state_r == ST_RUN) & (drop_cnt_r == CNT_ZERO) & ~Redirect;
  assign pop_s         = inst_valid_r & InstReady & ~Redirect;
  assign redirect_pc_s = NextPC & ~64'h3;
  assign IMemReqAddr   = fetch_pc_r;
  assign InstValid     = inst_valid_r;
  assign Instruction   = instruction_r;
  assign CurrentPC     = current_pc_r;

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state: any Redirect re-evaluates, DRAIN exits once the last wrong-path response is gone.
  always_comb begin
    state_nxt_s = state_r;
    if (Redirect) begin
      state_nxt_s = (drop_nxt_s != CNT_ZERO) ? ST_DRAIN : ST_RUN;
    end else begin
      case (state_r)
        ST_RUN:   state_nxt_s = ST_RUN;
        ST_DRAIN: state_nxt_s = (drop_nxt_s == CNT_ZERO) ? ST_RUN : ST_DRAIN;
        default:  state_nxt_s = ST_RUN;
      endcase
    end
  end

  // FSM output: request only in RUN with a free credit. Reset also blocks it in the reset cycle.
  always_comb begin
    IMemReqValid = 1'b0;
    if (!Reset && (state_r == ST_RUN) && credit_ok_s) begin
      IMemReqValid = 1'b1;
    end else begin
      IMemReqValid = 1'b0;
    end
  end

  // In-flight and drop counters. On a redirect every fetch still owed becomes wrong-path.
  always_comb begin
    out_nxt_s  = outstanding_r;
    drop_nxt_s = drop_cnt_r;
    if (req_fire_s && !rsp_take_s) begin
      out_nxt_s = outstanding_r + CNT_ONE;
    end else if (!req_fire_s && rsp_take_s) begin
      out_nxt_s = outstanding_r - CNT_ONE;
    end else begin
      out_nxt_s = outstanding_r;
    end
    if (Redirect) begin
      drop_nxt_s = out_nxt_s;
    end else if ((state_r == ST_DRAIN) && rsp_take_s && (drop_cnt_r != CNT_ZERO)) begin
      drop_nxt_s = drop_cnt_r - CNT_ONE;
    end else begin
      drop_nxt_s = drop_cnt_r;
    end
  end

  // PC tracking and queue bookkeeping.
  always_comb begin
    fetch_pc_nxt_s = fetch_pc_r;
    rsp_pc_nxt_s   = rsp_pc_r;
    count_nxt_s    = count_r;
    rd_ptr_nxt_s   = rd_ptr_r;
    wr_ptr_nxt_s   = wr_ptr_r;
    remain_s       = count_r - (pop_s ? CNT_ONE : CNT_ZERO);
    if (Redirect) begin
      fetch_pc_nxt_s = redirect_pc_s;
      rsp_pc_nxt_s   = redirect_pc_s;
      count_nxt_s    = CNT_ZERO;
      rd_ptr_nxt_s   = PTR_ZERO;
      wr_ptr_nxt_s   = PTR_ZERO;
    end else begin
      fetch_pc_nxt_s = req_fire_s ? (fetch_pc_r + 64'd4) : fetch_pc_r;
      rsp_pc_nxt_s   = push_s ? (rsp_pc_r + 64'd4) : rsp_pc_r;
      count_nxt_s    = remain_s + (push_s ? CNT_ONE : CNT_ZERO);
      rd_ptr_nxt_s   = pop_s ? ptr_inc(rd_ptr_r) : rd_ptr_r;
      wr_ptr_nxt_s   = push_s ? ptr_inc(wr_ptr_r) : wr_ptr_r;
    end
  end

  // Next head. A word pushed into a queue that is otherwise empty bypasses the array into the head registers.
  always_comb begin
    head_valid_nxt_s = 1'b0;
    head_inst_nxt_s  = 32'h0;
    head_pc_nxt_s    = rsp_pc_nxt_s;
    if (count_nxt_s == CNT_ZERO) begin
      head_valid_nxt_s = 1'b0;
      head_inst_nxt_s  = 32'h0;
      head_pc_nxt_s    = rsp_pc_nxt_s;
    end else if (remain_s == CNT_ZERO) begin
      head_valid_nxt_s = 1'b1;
      head_inst_nxt_s  = IMemRspData;
      head_pc_nxt_s    = rsp_pc_r;
    end else begin
      head_valid_nxt_s = 1'b1;
      head_inst_nxt_s  = q_inst_r[rd_ptr_nxt_s];
      head_pc_nxt_s    = q_pc_r[rd_ptr_nxt_s];
    end
  end

  // Datapath registers, queue storage and registered head outputs.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      fetch_pc_r    <= RESET_PC;
      rsp_pc_r      <= RESET_PC;
      outstanding_r <= CNT_ZERO;
      drop_cnt_r    <= CNT_ZERO;
      count_r       <= CNT_ZERO;
      rd_ptr_r      <= PTR_ZERO;
      wr_ptr_r      <= PTR_ZERO;
      inst_valid_r  <= 1'b0;
      instruction_r <= 32'h0;
      current_pc_r  <= RESET_PC;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        q_inst_r[i] <= 32'h0;
        q_pc_r[i]   <= 64'h0;
      end
    end else begin
      fetch_pc_r    <= fetch_pc_nxt_s;
      rsp_pc_r      <= rsp_pc_nxt_s;
      outstanding_r <= out_nxt_s;
      drop_cnt_r    <= drop_nxt_s;
      count_r       <= count_nxt_s;
      rd_ptr_r      <= rd_ptr_nxt_s;
      wr_ptr_r      <= wr_ptr_nxt_s;
      inst_valid_r  <= head_valid_nxt_s;
      instruction_r <= head_inst_nxt_s;
      current_pc_r  <= head_pc_nxt_s;
      if (push_s) begin
        q_inst_r[wr_ptr_r] <= IMemRspData;
        q_pc_r[wr_ptr_r]   <= rsp_pc_r;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Testbench for pc_fetch_unit (RESET_PC=0x100, QUEUE_DEPTH=2).
// A small memory model answers fetches one cycle after acceptance, and it can be stalled.
// Expected request addresses and expected decoded instructions are pushed into queues
// by the stimulus. Two monitors compare them against the DUT on every accepted request
// and every pop.
module tb_pc_fetch_unit;

  logic        CLK;
  logic        Reset;
  logic [63:0] NextPC;
  logic        Redirect;
  logic        IMemReqValid;
  logic [63:0] IMemReqAddr;
  logic        IMemReqReady;
  logic        IMemRspValid;
  logic [31:0] IMemRspData;
  logic        InstValid;
  logic [31:0] Instruction;
  logic [63:0] CurrentPC;
  logic        InstReady;

  int          n_checks = 0;
  int          n_errors = 0;
  int          acc_cnt  = 0;
  bit          mem_stall = 1'b0;
  logic [63:0] req_q [$];
  logic [63:0] exp_q [$];
  logic [63:0] mem_q [$];

  pc_fetch_unit #(.RESET_PC(64'h100), .QUEUE_DEPTH(2)) dut (
    .CLK(CLK), .Reset(Reset), .NextPC(NextPC), .Redirect(Redirect),
    .IMemReqValid(IMemReqValid), .IMemReqAddr(IMemReqAddr), .IMemReqReady(IMemReqReady),
    .IMemRspValid(IMemRspValid), .IMemRspData(IMemRspData),
    .InstValid(InstValid), .Instruction(Instruction), .CurrentPC(CurrentPC),
    .InstReady(InstReady)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [31:0] inst_of(input logic [63:0] pc);
    return pc[31:0] ^ 32'h1357_9BDF;
  endfunction

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Memory model: records accepts at the negedge and answers in order one cycle later.
  initial begin
    IMemRspValid = 1'b0;
    IMemRspData  = 32'h0;
    forever begin
      @(negedge CLK);
      if (Reset) begin
        mem_q.delete();
      end else if (IMemReqValid && IMemReqReady) begin
        mem_q.push_back(IMemReqAddr);
        acc_cnt++;
      end
      @(posedge CLK);
      #2;
      if (!mem_stall && mem_q.size() > 0) begin
        IMemRspValid = 1'b1;
        IMemRspData  = inst_of(mem_q.pop_front());
      end else begin
        IMemRspValid = 1'b0;
        IMemRspData  = 32'h0;
      end
    end
  end

  // Request monitor.
  initial begin
    forever begin
      @(negedge CLK);
      if (!Reset && IMemReqValid && IMemReqReady) begin
        check64("req_align", {62'd0, IMemReqAddr[1:0]}, 64'd0);
        if (req_q.size() > 0) check64("req_addr", IMemReqAddr, req_q.pop_front());
      end
    end
  end

  // Decode-side monitor: each pop must match the next expected instruction.
  initial begin : pop_mon
    logic [63:0] e;
    forever begin
      @(negedge CLK);
      if (!Reset && !Redirect && InstValid && InstReady) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL pop_unexpected: got pc %h inst %h, required no instruction", CurrentPC, Instruction);
        end else begin
          e = exp_q.pop_front();
          check64("pop_pc", CurrentPC, e);
          check64("pop_inst", {32'd0, Instruction}, {32'd0, inst_of(e)});
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    Reset    = 1'b1;
    Redirect = 1'b0;
    InstReady = 1'b0;
    req_q.delete();
    exp_q.delete();
    @(posedge CLK);
    #1;
    acc_cnt = 0;
    check64("rst_reqvalid", 64'(IMemReqValid), 64'd0);
    check64("rst_instvalid", 64'(InstValid), 64'd0);
    check64("rst_instruction", {32'd0, Instruction}, 64'd0);
    check64("rst_currentpc", CurrentPC, 64'h100);
    @(posedge CLK);
    #1;
    Reset = 1'b0;
  endtask

  task automatic push_seq(input logic [63:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      req_q.push_back(base + 64'(4 * i));
      exp_q.push_back(base + 64'(4 * i));
    end
  endtask

  task automatic consume(input int n);
    int got;
    int guard;
    got = 0;
    guard = 0;
    InstReady = 1'b1;
    while (got < n && guard < 200) begin
      @(negedge CLK);
      if (InstValid && InstReady && !Redirect && !Reset) got++;
      guard++;
    end
    check64("consume_cnt", 64'(got), 64'(n));
    @(posedge CLK);
    #1;
    InstReady = 1'b0;
  endtask

  task automatic wait_acc(input int target);
    int guard;
    guard = 0;
    while (acc_cnt < target && guard < 100) begin
      @(posedge CLK);
      #1;
      guard++;
    end
    check64("wait_acc", 64'(acc_cnt), 64'(target));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; Redirect = 1'b0; NextPC = 64'h0;
    IMemReqReady = 1'b1; InstReady = 1'b0;

    // 1: sequential fetch from RESET_PC, instructions in order.
    do_reset();
    push_seq(64'h100, 6);
    consume(6);

    // 2: no consumption -> exactly two requests, then one request per pop.
    do_reset();
    push_seq(64'h100, 4);
    idle(10);
    check64("t2_acc2", 64'(acc_cnt), 64'd2);
    check64("t2_reqvalid_full", 64'(IMemReqValid), 64'd0);
    check64("t2_head_valid", 64'(InstValid), 64'd1);
    check64("t2_head_pc", CurrentPC, 64'h100);
    check64("t2_head_inst", {32'd0, Instruction}, {32'd0, inst_of(64'h100)});
    consume(1);
    idle(5);
    check64("t2_acc3", 64'(acc_cnt), 64'd3);
    check64("t2_reqvalid_full2", 64'(IMemReqValid), 64'd0);
    consume(1);
    idle(5);
    check64("t2_acc4", 64'(acc_cnt), 64'd4);
    consume(2);

    // 3: redirect to 0x2003 with two fetches outstanding.
    mem_stall = 1'b1;
    do_reset();
    req_q.push_back(64'h100);
    req_q.push_back(64'h104);
    wait_acc(2);
    idle(2);
    check64("t3_credit_out", 64'(IMemReqValid), 64'd0);
    Redirect = 1'b1;
    NextPC = 64'h2003;
    @(posedge CLK);
    #1;
    Redirect = 1'b0;
    check64("t3_drain_noreq", 64'(IMemReqValid), 64'd0);
    check64("t3_flushed", 64'(InstValid), 64'd0);
    check64("t3_fetchpc", IMemReqAddr, 64'h2000);
    push_seq(64'h2000, 2);
    mem_stall = 1'b0;
    consume(2);

    // 4: redirect in the same cycle as a request accept and a response.
    do_reset();
    req_q.push_back(64'h100);
    req_q.push_back(64'h104);
    push_seq(64'h3000, 2);
    @(posedge CLK);
    #1;
    Redirect = 1'b1;
    NextPC = 64'h3000;
    @(negedge CLK);
    check64("t4_setup_req", 64'(IMemReqValid), 64'd1);
    check64("t4_setup_rsp", 64'(IMemRspValid), 64'd1);
    @(posedge CLK);
    #1;
    Redirect = 1'b0;
    consume(2);

    // 5: sequential increment wraps from the top of the address space to 0.
    IMemReqReady = 1'b0;
    do_reset();
    Redirect = 1'b1;
    NextPC = 64'hFFFF_FFFF_FFFF_FFFE;
    @(posedge CLK);
    #1;
    Redirect = 1'b0;
    check64("t5_load_aligned", IMemReqAddr, 64'hFFFF_FFFF_FFFF_FFFC);
    check64("t5_reqvalid", 64'(IMemReqValid), 64'd1);
    IMemReqReady = 1'b1;
    push_seq(64'hFFFF_FFFF_FFFF_FFFC, 3);
    consume(3);

    // 6: Reset while draining restarts cleanly at RESET_PC.
    mem_stall = 1'b1;
    do_reset();
    wait_acc(2);
    Redirect = 1'b1;
    NextPC = 64'h4000;
    @(posedge CLK);
    #1;
    Redirect = 1'b0;
    check64("t6_in_drain", 64'(IMemReqValid), 64'd0);
    idle(1);
    do_reset();
    #1;
    check64("t6_restart_valid", 64'(IMemReqValid), 64'd1);
    check64("t6_restart_addr", IMemReqAddr, 64'h100);
    check64("t6_instvalid", 64'(InstValid), 64'd0);
    check64("t6_currentpc", CurrentPC, 64'h100);
    mem_stall = 1'b0;
    push_seq(64'h100, 2);
    consume(2);

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
